// File: rtl/serial_adder.sv
// ============================================================================
// serial_adder : bit-serial adder, one full-adder bit per clock, LSB first
// Rev 1.0
// ============================================================================
`default_nettype none

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADD  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic w_fa_s;
  logic w_fa_c;
  logic w_last;

  assign w_fa_s = a_q[0] ^ b_q[0] ^ carry_q;
  assign w_fa_c = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));
  assign w_last = (cnt_q == C_LAST_BIT);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = ADD;
      ADD:     if (w_last) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    in_ready  = (state_q == IDLE);
    busy      = (state_q == ADD);
    out_valid = (state_q == DONE);
  end

  // Datapath: operand shifters, carry, bit counter, result registers
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
        end
      end
      ADD: begin
        acc_d   = {w_fa_s, acc_q[WIDTH-1:1]};
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = w_fa_c;
        // Counter parks on the last bit rather than wrapping
        if (!w_last) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          sum_d  = {w_fa_s, acc_q[WIDTH-1:1]};
          cout_d = w_fa_c;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

`default_nettype wire

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand and sum width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  operand set a/b/cin presented.
REQ-005 in_ready  output  1  block can accept an operand set.
REQ-006 a  input  WIDTH  addend A.
REQ-007 b  input  WIDTH  addend B.
REQ-008 cin  input  1  carry-in to bit 0.
REQ-009 out_valid  output  1  sum/cout hold a completed result.
REQ-010 out_ready  input  1  downstream consumes result.
REQ-011 sum  output  WIDTH  registered result, (a+b+cin) mod 2^WIDTH.
REQ-012 cout  output  1  registered carry out of bit WIDTH-1.
REQ-013 busy  output  1  high while an addition is in progress (ADD state).

Function
REQ-014 The block SHALL be a bit-serial adder: one single-bit full-adder cell plus a 1-bit carry register, processing one bit per clock, LSB first.
REQ-015 The FSM SHALL have exactly three states: IDLE, ADD, DONE.
REQ-016 in_ready SHALL equal (state == IDLE); out_valid SHALL equal (state == DONE); busy SHALL equal (state == ADD).
REQ-017 Accept: a rising edge with state IDLE and in_valid=1 SHALL capture a, b into shift registers, cin into the carry register, clear the bit counter and enter ADD.
REQ-018 With in_valid=0 in IDLE the block SHALL stay in IDLE with no register changes.
REQ-019 Each ADD edge SHALL compute s = a0^b0^c and c' = a0&b0 | c&(a0^b0) on the current LSBs, shift s into the sum shift register from the MSB end, shift a and b right by one, store c' and increment the bit counter.
REQ-020 On the ADD edge that processes bit WIDTH-1, the block SHALL load sum and cout output registers with the completed result and enter DONE.
REQ-021 Latency: out_valid SHALL rise exactly WIDTH clock edges after the accepting edge.
REQ-022 In ADD, in_valid, a, b, cin and out_ready SHALL be ignored; changes to a/b/cin after acceptance SHALL NOT affect the result.
REQ-023 In DONE, sum and cout SHALL be held stable while out_ready=0, for any number of cycles.
REQ-024 In DONE with out_ready=1 at a rising edge the block SHALL return to IDLE; in_ready SHALL be asserted in the following cycle (no same-cycle accept/release overlap).
REQ-025 sum and cout SHALL retain the last result after leaving DONE until the next completion overwrites them.
REQ-026 The bit counter SHALL be $clog2(WIDTH) bits wide and SHALL NOT wrap within an operation.
REQ-027 The maximum throughput SHALL be one result per WIDTH+2 cycles.

Reset
REQ-028 rst_n=0 SHALL immediately, without waiting for clk, force state IDLE and clear sum, cout, carry, counter and shift registers to 0.
REQ-029 Reset values: in_ready=1, out_valid=0, busy=0, sum=0, cout=0.
REQ-030 No operand transfer SHALL occur while rst_n=0, regardless of in_valid.
REQ-031 Reset asserted during ADD or DONE SHALL abort the operation; no partial result SHALL appear at sum/cout.
REQ-032 After rst_n deasserts, the first rising edge SHALL behave as a normal IDLE edge.

Verification (WIDTH=8)
REQ-033 a=0x00, b=0x00, cin=0, out_ready=1 -> out_valid rises 8 edges after accept; sum=0x00, cout=0.
REQ-034 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; a=0x3C, b=0x42, cin=1 -> sum=0x7F, cout=0.
REQ-035 Back-pressure: a=0xA5, b=0x5A, cin=1, out_ready=0 for 5 cycles after out_valid -> sum=0x00, cout=1 held for all 5 cycles; in_ready=0 throughout; in_ready=1 one cycle after the out_ready edge.
REQ-036 Ignore while busy: toggle in_valid and change a/b every cycle during ADD -> result equals the originally accepted operands; no second operation starts.
REQ-037 rst_n pulsed low after 4 ADD edges of a=0xFF, b=0xFF -> sum=0x00, cout=0, out_valid=0 asynchronously; a following a=0x10, b=0x20, cin=0 gives sum=0x30, cout=0.
REQ-038 Randomised: 1000 operand sets with random in_valid/out_ready gaps -> every {cout,sum} equals a+b+cin, and latency is exactly 8 edges per operation.
